// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - N-digit multiplexed seven-segment driver with blank-gap scanning and blink
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 64,
  localparam int AW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  CLEAR,
  input  logic                  WR_EN,
  input  logic [AW-1:0]         WR_ADDR,
  input  logic [4:0]            WR_GLYPH,
  input  logic                  WR_DP,
  input  logic                  WR_BLINK,
  output logic [NUM_DIGITS-1:0] SEL,
  output logic [7:0]            DIGIT,
  output logic                  FRAME_TICK
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [AW-1:0]           idx, idx_next;
  logic [PW-1:0]           presc, presc_next;
  logic                    wrap;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [4:0]              glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   dp_bits;
  logic [NUM_DIGITS-1:0]   blink_bits;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic [7:0]              digit_d;

  // Glyph code to active-low {dp,g,f,e,d,c,b,a}; dp is merged in later.
  function automatic logic [7:0] decode(input logic [4:0] g);
    logic [7:0] seg;
    case (g)
      5'h00: seg = 8'hC0;
      5'h01: seg = 8'hF9;
      5'h02: seg = 8'hA4;
      5'h03: seg = 8'hB0;
      5'h04: seg = 8'h99;
      5'h05: seg = 8'h92;
      5'h06: seg = 8'h82;
      5'h07: seg = 8'hF8;
      5'h08: seg = 8'h80;
      5'h09: seg = 8'h90;
      5'h0A: seg = 8'h88;
      5'h0B: seg = 8'h83;
      5'h0C: seg = 8'hC6;
      5'h0D: seg = 8'hA1;
      5'h0E: seg = 8'h86;
      5'h0F: seg = 8'h8E;
      5'h10: seg = 8'hC7;
      5'h11: seg = 8'hAF;
      5'h12: seg = 8'h8E;
      5'h13: seg = 8'h83;
      5'h14: seg = 8'hBF;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Scan state register: state, digit index and slot prescaler.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      idx   <= '0;
      presc <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      presc <= presc_next;
    end
  end

  // Next-state logic; wrap marks the drive-to-blank step that returns to digit 0.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    presc_next = presc;
    wrap       = 1'b0;
    if (!EN) begin
      state_next = S_IDLE;
      idx_next   = '0;
      presc_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_next = S_BLANK;
          idx_next   = '0;
          presc_next = '0;
        end
        S_BLANK: begin
          state_next = S_DRIVE;
          presc_next = '0;
        end
        S_DRIVE: begin
          if (presc == PRESC_LAST) begin
            state_next = S_BLANK;
            presc_next = '0;
            if (idx == IDX_LAST) begin
              idx_next = '0;
              wrap     = 1'b1;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            presc_next = presc + 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          idx_next   = '0;
          presc_next = '0;
        end
      endcase
    end
  end

  // Blink phase flips after every BLINK_DIV frame wraps; cleared whenever scanning stops.
  always_ff @(posedge CLK) begin
    if (RESET || !EN) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Glyph register file; clear beats a same-cycle write, out-of-range addresses are dropped.
  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        glyph[i] <= 5'h1F;
      end
      dp_bits    <= '0;
      blink_bits <= '0;
    end else if (WR_EN && (int'(WR_ADDR) < NUM_DIGITS)) begin
      glyph[WR_ADDR]      <= WR_GLYPH;
      dp_bits[WR_ADDR]    <= WR_DP;
      blink_bits[WR_ADDR] <= WR_BLINK;
    end
  end

  // Pin values for the current state; blinking digits keep their anode but go dark.
  always_comb begin
    sel_d   = '1;
    digit_d = 8'hFF;
    if (state == S_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sel_d[i] = (idx != AW'(i));
      end
      if (!(blink_bits[idx] && blink_phase)) begin
        digit_d = decode(glyph[idx]) & {~dp_bits[idx], 7'h7F};
      end
    end
  end

  // Registered pin drivers, one cycle behind the scan state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEL        <= '1;
      DIGIT      <= 8'hFF;
      FRAME_TICK <= 1'b0;
    end else begin
      SEL        <= sel_d;
      DIGIT      <= digit_d;
      FRAME_TICK <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed self-checking bench for seven_seg_scan
module tb_seven_seg_scan;

  logic       CLK;
  logic       RESET;
  logic       EN;
  logic       CLEAR;
  logic       WR_EN;
  logic [1:0] WR_ADDR;
  logic [4:0] WR_GLYPH;
  logic       WR_DP;
  logic       WR_BLINK;
  logic [3:0] SEL;
  logic [7:0] DIGIT;
  logic       FRAME_TICK;

  logic       EN5;
  logic       WR_EN5;
  logic [2:0] WR_ADDR5;
  logic [4:0] WR_GLYPH5;
  logic [4:0] SEL5;
  logic [7:0] DIGIT5;
  logic       FRAME_TICK5;

  int         checks = 0;
  int         failures = 0;
  int         pos = 0;
  logic [7:0] exp_seg [4];
  logic [3:0] blink_mask;

  seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLEAR(CLEAR), .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR), .WR_GLYPH(WR_GLYPH), .WR_DP(WR_DP), .WR_BLINK(WR_BLINK),
    .SEL(SEL), .DIGIT(DIGIT), .FRAME_TICK(FRAME_TICK)
  );

  seven_seg_scan #(.NUM_DIGITS(5), .REFRESH_DIV(1), .BLINK_DIV(1)) u_dut5 (
    .CLK(CLK), .RESET(RESET), .EN(EN5), .CLEAR(CLEAR), .WR_EN(WR_EN5),
    .WR_ADDR(WR_ADDR5), .WR_GLYPH(WR_GLYPH5), .WR_DP(1'b0), .WR_BLINK(1'b0),
    .SEL(SEL5), .DIGIT(DIGIT5), .FRAME_TICK(FRAME_TICK5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {tick,sel,digit} p cycles after EN rises: 2-cycle lead-in, then 20-cycle frames.
  function automatic logic [12:0] expect_out(input int p);
    logic [12:0] r;
    logic [3:0]  s;
    int          k, f, d;
    r = {1'b0, 4'hF, 8'hFF};
    if (p >= 2) begin
      k = (p - 2) % 20;
      f = (p - 2) / 20;
      d = k / 5;
      if (k % 5 != 0) begin
        s = 4'b0001 << d;
        r[11:8] = ~s;
        r[7:0]  = (blink_mask[d] && ((f / 2) % 2 == 1)) ? 8'hFF : exp_seg[d];
      end
      r[12] = (k == 19);
    end
    return r;
  endfunction

  task automatic step();
    @(negedge CLK);
    pos++;
    check_val($sformatf("scan_p%0d", pos), {19'd0, FRAME_TICK, SEL, DIGIT}, {19'd0, expect_out(pos)});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic start_en();
    EN  = 1'b1;
    pos = 0;
  endtask

  task automatic stop_en(input string tag);
    EN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_val(tag, {19'd0, FRAME_TICK, SEL, DIGIT}, 32'h0FFF);
  endtask

  task automatic wr(input logic [1:0] a, input logic [4:0] g, input logic dp, input logic bl);
    WR_ADDR  = a;
    WR_GLYPH = g;
    WR_DP    = dp;
    WR_BLINK = bl;
    WR_EN    = 1'b1;
    @(negedge CLK);
    WR_EN    = 1'b0;
  endtask

  task automatic load_lrfb();
    wr(2'd0, 5'h10, 1'b0, 1'b0);
    wr(2'd1, 5'h11, 1'b0, 1'b0);
    wr(2'd2, 5'h12, 1'b0, 1'b0);
    wr(2'd3, 5'h13, 1'b0, 1'b0);
    exp_seg[0] = 8'hC7;
    exp_seg[1] = 8'hAF;
    exp_seg[2] = 8'h8E;
    exp_seg[3] = 8'h83;
    blink_mask = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    RESET = 1'b1; EN = 1'b0; CLEAR = 1'b0; WR_EN = 1'b0;
    WR_ADDR = '0; WR_GLYPH = '0; WR_DP = 1'b0; WR_BLINK = 1'b0;
    EN5 = 1'b0; WR_EN5 = 1'b0; WR_ADDR5 = '0; WR_GLYPH5 = '0;
    blink_mask = 4'b0000;
    for (int i = 0; i < 4; i++) exp_seg[i] = 8'hFF;

    repeat (3) @(negedge CLK);
    check_val("reset_out", {19'd0, FRAME_TICK, SEL, DIGIT}, 32'h0FFF);
    RESET = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      check_val("idle_en0", {19'd0, FRAME_TICK, SEL, DIGIT}, 32'h0FFF);
    end

    // Direction glyphs, three full frames.
    load_lrfb();
    start_en();
    run(62);

    // Hex 5 with decimal point on digit 2.
    stop_en("stop_a");
    wr(2'd2, 5'h05, 1'b1, 1'b0);
    exp_seg[2] = 8'h12;
    start_en();
    run(42);

    // Mid-slot write of dash to digit 2: old value one more cycle, then new.
    run(11);
    WR_ADDR = 2'd2; WR_GLYPH = 5'h14; WR_DP = 1'b0; WR_BLINK = 1'b0; WR_EN = 1'b1;
    step();
    WR_EN = 1'b0;
    exp_seg[2] = 8'hBF;
    run(27);

    // Blink on digit 1: two frames lit, two dark.
    stop_en("stop_b");
    wr(2'd1, 5'h11, 1'b0, 1'b1);
    blink_mask = 4'b0010;
    start_en();
    run(82);

    // EN dropped during digit 2, then restart from digit 0.
    stop_en("stop_c");
    start_en();
    run(14);
    stop_en("en_drop_mid");
    start_en();
    run(22);

    // RESET during digit 2 with EN held high.
    stop_en("stop_d");
    start_en();
    run(14);
    RESET = 1'b1;
    @(negedge CLK);
    check_val("reset_mid", {19'd0, FRAME_TICK, SEL, DIGIT}, 32'h0FFF);
    @(negedge CLK);
    check_val("reset_hold", {19'd0, FRAME_TICK, SEL, DIGIT}, 32'h0FFF);
    EN = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    load_lrfb();
    start_en();
    run(22);

    // CLEAR beats a same-cycle write; glyph 0x1A decodes blank.
    stop_en("stop_e");
    CLEAR = 1'b1;
    WR_ADDR = 2'd0; WR_GLYPH = 5'h00; WR_DP = 1'b1; WR_BLINK = 1'b0; WR_EN = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    WR_EN = 1'b0;
    wr(2'd3, 5'h1A, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_seg[i] = 8'hFF;
    start_en();
    run(22);

    // Five-digit instance: address 5 is out of range and ignored, address 4 is live.
    WR_ADDR5 = 3'd5; WR_GLYPH5 = 5'h00; WR_EN5 = 1'b1;
    @(negedge CLK);
    WR_ADDR5 = 3'd4; WR_GLYPH5 = 5'h00;
    @(negedge CLK);
    WR_EN5 = 1'b0;
    EN5 = 1'b1;
    seen = 0;
    repeat (24) begin
      @(negedge CLK);
      if (SEL5 == 5'b01111) begin
        seen++;
        check_val("d5_digit4", {24'd0, DIGIT5}, 32'hC0);
      end else begin
        check_val("d5_others", {24'd0, DIGIT5}, 32'hFF);
      end
    end
    check_val("d5_digit4_slots", seen, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
